// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_DW  = 32;
  localparam int unsigned WB_NREQ = 3;
  localparam int unsigned WB_GW   = $clog2(WB_NREQ);

  typedef logic [WB_GW-1:0] grant_id_t;

  // Writeback source indices
  localparam grant_id_t WB_ALU    = grant_id_t'(0);
  localparam grant_id_t WB_LOAD   = grant_id_t'(1);
  localparam grant_id_t WB_MULDIV = grant_id_t'(2);

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [PW-1:0] idx_c,
  output logic          any_c
);

  // Search ptr, ptr+1, ... N-1, 0, ... ptr-1 without a modulo operator
  always_comb begin
    int unsigned j;
    j     = 0;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any_c && req[PW'(j)]) begin
        any_c           = 1'b1;
        idx_c           = PW'(j);
        gnt_c[PW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// writeback sources, with a registered Wt_* output stage.
// Build option: REGFILE_WB_FIXED_PRIO_EN selects fixed lowest-index priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = WB_NREQ,
  parameter int unsigned AW   = REG_AW,
  parameter int unsigned DW   = REG_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     stall,
  output logic [AW-1:0]            Wt_addr,
  output logic [DW-1:0]            Wt_data,
  output logic                     Wt_en,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int unsigned GW = $clog2(NREQ);

  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] gnt_c;
  logic [GW-1:0]   idx_c;
  logic [GW-1:0]   pick_ptr;
  logic            any_c;

  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];

  logic            wt_en_q,    wt_en_d;
  logic [AW-1:0]   wt_addr_q,  wt_addr_d;
  logic [DW-1:0]   wt_data_q,  wt_data_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;

  // Stall masks every request so no grant can be issued
  assign req_eff = stall ? '0 : req_valid;

`ifdef REGFILE_WB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [GW-1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`endif

  rr_pick #(
    .N  (NREQ),
    .PW (GW)
  ) u_pick (
    .req   (req_eff),
    .ptr   (pick_ptr),
    .gnt_c (gnt_c),
    .idx_c (idx_c),
    .any_c (any_c)
  );

  // No handshake may complete while reset is asserted
  assign req_ready = rst ? gnt_c : '0;

  // Unpack the flat request buses into per-requester slices
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_a[i] = req_addr[i*AW +: AW];
      data_a[i] = req_data[i*DW +: DW];
    end
  end

  // Next-state: capture the granted write; r0 writes are consumed but not enabled
  always_comb begin
    wt_en_d    = 1'b0;
    wt_addr_d  = wt_addr_q;
    wt_data_d  = wt_data_q;
    grant_id_d = grant_id_q;
`ifndef REGFILE_WB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    if (any_c) begin
      wt_addr_d  = addr_a[idx_c];
      wt_data_d  = data_a[idx_c];
      grant_id_d = idx_c;
      wt_en_d    = (addr_a[idx_c] != '0);
`ifndef REGFILE_WB_FIXED_PRIO_EN
      ptr_d      = (idx_c == GW'(NREQ-1)) ? '0 : idx_c + GW'(1);
`endif
    end
  end

  // Output stage and round-robin pointer; reset discards any pending write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wt_en_q    <= 1'b0;
      wt_addr_q  <= '0;
      wt_data_q  <= '0;
      grant_id_q <= '0;
`ifndef REGFILE_WB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      wt_en_q    <= wt_en_d;
      wt_addr_q  <= wt_addr_d;
      wt_data_q  <= wt_data_d;
      grant_id_q <= grant_id_d;
`ifndef REGFILE_WB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign Wt_en    = wt_en_q;
  assign Wt_addr  = wt_addr_q;
  assign Wt_data  = wt_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
module tb_regfile_wb_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
`ifdef REGFILE_WB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              stall;
  logic [AW-1:0]     Wt_addr;
  logic [DW-1:0]     Wt_data;
  logic              Wt_en;
  logic [1:0]        grant_id;

  logic [DW-1:0]     rf [32];

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .Wt_addr   (Wt_addr),
    .Wt_data   (Wt_data),
    .Wt_en     (Wt_en),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits on the negedge inside the Wt_* cycle
  always @(negedge clk) begin
    if (Wt_en) rf[Wt_addr] <= Wt_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] g;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst       = 1'b0;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;

    // 1. Reset/idle
    #2;
    check("rst_wt_en",   32'(Wt_en),     32'd0);
    check("rst_wt_addr", 32'(Wt_addr),   32'd0);
    check("rst_wt_data", Wt_data,        32'd0);
    check("rst_ready",   32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_wt_en_cyc",   32'(Wt_en),     32'd0);
      check("rst_ready_cyc",   32'(req_ready), 32'd0);
      check("rst_grant_id",    32'(grant_id),  32'd0);
    end
    rst       = 1'b1;
    req_valid = 3'b000;
    tick();
    check("idle_wt_en", 32'(Wt_en), 32'd0);

    // 2. Single write from requester 0
    req_valid          = 3'b001;
    req_addr[0*AW +: AW] = 5'd5;
    req_data[0*DW +: DW] = 32'hDEADBEEF;
    #1;
    check("single_ready", 32'(req_ready), 32'b001);
    tick();
    check("single_wt_en",    32'(Wt_en),    32'd1);
    check("single_wt_addr",  32'(Wt_addr),  32'd5);
    check("single_wt_data",  Wt_data,       32'hDEADBEEF);
    check("single_grant_id", 32'(grant_id), 32'd0);

    // 4. r0 write from requester 1 is consumed but not enabled
    req_valid            = 3'b010;
    req_addr[1*AW +: AW] = 5'd0;
    req_data[1*DW +: DW] = 32'h1234;
    #1;
    check("r0_ready", 32'(req_ready), 32'b010);
    tick();
    check("r0_wt_en",    32'(Wt_en),    32'd0);
    check("r0_grant_id", 32'(grant_id), 32'd1);
    check("r0_wt_data",  Wt_data,       32'h1234);

    // 5. Stall: ptr is 2 after the r0 drop, so req2 wins with all valid
    req_valid            = FIXED ? 3'b100 : 3'b111;
    req_addr[0*AW +: AW] = 5'd10;
    req_data[0*DW +: DW] = 32'hA0;
    req_addr[1*AW +: AW] = 5'd11;
    req_data[1*DW +: DW] = 32'hA1;
    req_addr[2*AW +: AW] = 5'd7;
    req_data[2*DW +: DW] = 32'h7777;
    #1;
    check("ptr_after_r0_ready", 32'(req_ready), 32'b100);
    tick();
    check("stall_acc_wt_en",    32'(Wt_en),    32'd1);
    check("stall_acc_wt_addr",  32'(Wt_addr),  32'd7);
    check("stall_acc_grant_id", 32'(grant_id), 32'd2);
    stall     = 1'b1;
    req_valid = 3'b011;
    #1;
    check("stall_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_wt_en",   32'(Wt_en),     32'd0);
      check("stall_wt_addr", 32'(Wt_addr),   32'd7);
      check("stall_ready_c", 32'(req_ready), 32'd0);
    end
    stall                = 1'b0;
    req_valid            = 3'b111;
    req_addr[2*AW +: AW] = 5'd12;
    req_data[2*DW +: DW] = 32'hA2;

    // 3. Round-robin under full contention, starting from index 0
    for (int k = 0; k < 6; k++) begin
      g = FIXED ? 3'd0 : 3'(k % 3);
      #1;
      check("rr_ready", 32'(req_ready), 32'(3'b001 << g));
      tick();
      check("rr_wt_en",    32'(Wt_en),    32'd1);
      check("rr_grant_id", 32'(grant_id), 32'(g));
      check("rr_wt_addr",  32'(Wt_addr),  32'd10 + 32'(g));
    end

    // 6. Reset mid-operation while a write to r9 is in the output stage
    req_valid            = 3'b001;
    req_addr[0*AW +: AW] = 5'd9;
    req_data[0*DW +: DW] = 32'h9999;
    tick();
    check("mid_wt_en_pre",   32'(Wt_en),   32'd1);
    check("mid_wt_addr_pre", 32'(Wt_addr), 32'd9);
    #1;
    rst = 1'b0;
    #1;
    check("mid_wt_en",   32'(Wt_en),     32'd0);
    check("mid_wt_addr", 32'(Wt_addr),   32'd0);
    check("mid_ready",   32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    check("mid_rf9_untouched", rf[9], 32'd0);
    check("rf5_written",  rf[5],  32'hDEADBEEF);
    check("rf0_never",    rf[0],  32'd0);
    if (!FIXED) check("rf12_written", rf[12], 32'hA2);

    rst       = 1'b1;
    req_valid = 3'b000;
    tick();
    check("post_wt_en", 32'(Wt_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between several writeback sources, e.g. ALU result, load unit and multiply/divide unit.
- Uses a valid/ready handshake per requester, round-robin grant and a registered output stage.
- Sits between the execute/memory writeback paths and the register file's Wt_addr/Wt_data/Wt_en inputs.
- Guarantees at most one register-file write per cycle, with fair service under contention.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous active-low reset
req_valid  input  NREQ  requester i has a pending write
req_addr  input  NREQ*AW  packed destination addresses; slice i = [i*AW +: AW]
req_data  input  NREQ*DW  packed write data; slice i = [i*DW +: DW]
req_ready  output  NREQ  one-hot (or zero) grant; transfer when valid&ready
stall  input  1  hazard-unit freeze; blocks all grants
Wt_addr  output  AW  register-file write address (registered)
Wt_data  output  DW  register-file write data (registered)
Wt_en  output  1  register-file write enable (registered)
grant_id  output  $clog2(NREQ)  index of requester that produced current Wt_* (registered)

Behaviour:
- Reset (rst=0, asynchronous):
  - Wt_en=0, Wt_addr=0, Wt_data=0, grant_id=0.
  - Round-robin pointer ptr=0.
  - req_ready forced to 0 while rst=0.
  - Any write held in the output stage is discarded and never reaches the register file.
- Grant (combinational):
  - If stall=0, pick the first i with req_valid[i]=1, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - req_ready[i]=1 for that i only.
  - No valid requests or stall=1 -> req_ready=0.
  - req_ready never depends on req_addr or req_data.
- Accept (posedge, grant g exists):
  - Wt_addr<=req_addr[g], Wt_data<=req_data[g], grant_id<=g.
  - Wt_en<=1 if req_addr[g]!=0, else 0. An r0 write is consumed and silently dropped.
  - ptr<=(g+1) mod NREQ.
- No accept (posedge):
  - Wt_en<=0; Wt_addr, Wt_data and grant_id hold; ptr holds.
- Latency:
  - Accept at edge N -> Wt_* valid during cycle N..N+1.
  - Register file commits at the negedge inside that cycle.
  - Throughput 1 write/cycle.
- Requester rule:
  - req_valid, once high, stays high with stable addr/data until accepted.
  - The bench flags violations; the arbiter's behaviour on a violation is unspecified.
- Ordering:
  - Writes reach the register file in grant order.
  - Same address from two requesters in consecutive grants -> later grant's data remains.
- Stall:
  - A write already in the output stage still completes (Wt_en high for that one cycle).
  - Wt_en is 0 from the next edge while stall=1.
  - ptr is frozen during stall.
- Fairness: with all NREQ valid continuously, each requester is granted exactly once in every NREQ consecutive accepts.
- Wrap: ptr wraps NREQ-1 -> 0; non-power-of-2 NREQ must never yield ptr>=NREQ.
- Reset release: first grant possible on the first posedge with rst=1, using ptr=0.

Optional Feature:
REGFILE_WB_FIXED_PRIO_EN
- Defined:
  - Fixed priority, lowest index wins; ptr logic removed.
  - Continuous requests from lower indices may starve higher ones.
  - All other behaviour unchanged.
- Undefined (default): round-robin as specified above.

Decomposition:
- Shared package regfile_pkg:
  - REG_AW=5, REG_DW=32 and default NREQ.
  - grant_id typedef.
  - Writeback source index constants: WB_ALU=0, WB_LOAD=1, WB_MULDIV=2.
- Sub-module rr_pick:
  - Purely combinational rotate-and-priority-encode.
  - Inputs: request vector and ptr. Outputs: one-hot grant, index, any flag.
  - Under REGFILE_WB_FIXED_PRIO_EN it is called with ptr tied to 0.
  - Reused by future arbiters.

Test Plan:
1. Reset/idle:
   - Stimulus: hold rst=0 for 3 cycles with req_valid=3'b111, then release rst and drive req_valid=3'b000.
   - Required: Wt_en=0, Wt_addr=0, Wt_data=0 and req_ready=0 throughout reset; Wt_en=0 after release.
2. Single write:
   - Stimulus: req0 addr=5, data=32'hDEADBEEF.
   - Required: req_ready=3'b001 in the same cycle; next cycle Wt_en=1, Wt_addr=5, Wt_data=DEADBEEF, grant_id=0.
3. Round-robin:
   - Stimulus: all three requesters held valid for 6 accepts.
   - Required: grant_id sequence 0,1,2,0,1,2 with no gaps in Wt_en.
   - Under REGFILE_WB_FIXED_PRIO_EN: 0,0,0,... while req0 is re-asserted each cycle.
4. r0 drop:
   - Stimulus: req1 addr=0, data=32'h1234.
   - Required: accepted (req_ready[1]=1); next cycle Wt_en=0; ptr advances to 2.
5. Stall:
   - Stimulus: accept req2 (addr 7) at edge N; stall=1 for cycles N+1..N+3.
   - Required: Wt_en=1 only in the cycle after N; req_ready=0 during stall; ptr unchanged.
   - The next grant after stall=0 starts from index 0.
6. Reset mid-operation:
   - Stimulus: assert rst=0 asynchronously between edges while Wt_en=1, addr 9.
   - Required: Wt_en drops immediately; register 9 is not written at the following negedge.
